// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: read-return tag
// encoding, default bus widths and a saturating counter helper.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_IF   = 2'd1,
    PEND_DM   = 2'd2
  } pend_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : (val + 16'd1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// memory stage; DM has priority, with a starvation guard for IF.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              stall_if,
  output logic              stall_dm,
  output logic [15:0]       conflict_cnt
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt_r;
  logic [3:0]  starve_next_s;
  pend_e       pend_r;
  pend_e       pend_next_s;
  logic [15:0] conflict_cnt_r;
  logic        if_gnt_s;
  logic        dm_gnt_s;

  // Grant decision: DM wins a conflict unless IF has waited STARVE_MAX cycles
  always_comb begin
    if_gnt_s = 1'b0;
    dm_gnt_s = 1'b0;
    if (rst) begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end else if (if_req && dm_req) begin
      if (starve_cnt_r == STARVE_MAX_C) begin
        if_gnt_s = 1'b1;
      end else begin
        dm_gnt_s = 1'b1;
      end
    end else begin
      if_gnt_s = if_req;
      dm_gnt_s = dm_req;
    end
  end

  // Starvation counter next value, clamped at STARVE_MAX
  always_comb begin
    starve_next_s = 4'd0;
    if (if_req && !if_gnt_s) begin
      if (starve_cnt_r < STARVE_MAX_C) begin
        starve_next_s = starve_cnt_r + 4'd1;
      end else begin
        starve_next_s = starve_cnt_r;
      end
    end else begin
      starve_next_s = 4'd0;
    end
  end

  // Read-return tag next state: remembers which port owns next cycle's mem_q
  always_comb begin
    pend_next_s = PEND_NONE;
    if (if_gnt_s) begin
      pend_next_s = PEND_IF;
    end else if (dm_gnt_s && !dm_we) begin
      pend_next_s = PEND_DM;
    end else begin
      pend_next_s = PEND_NONE;
    end
  end

  // RAM port drive from the winning requester; idle bus is all zeros
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (if_gnt_s) begin
      mem_addr = if_addr;
    end else if (dm_gnt_s) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_wren  = dm_we;
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wren  = 1'b0;
    end
  end

  // State registers: starvation counter, return tag, conflict statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r   <= 4'd0;
      pend_r         <= PEND_NONE;
      conflict_cnt_r <= 16'd0;
    end else begin
      starve_cnt_r <= starve_next_s;
      pend_r       <= pend_next_s;
      if (if_req && dm_req) begin
        conflict_cnt_r <= sat_inc16(conflict_cnt_r);
      end
    end
  end

  // The rst gate covers a pre-reset grant still tagged in pend_r
  assign if_rvalid    = (pend_r == PEND_IF) && !rst;
  assign dm_rvalid    = (pend_r == PEND_DM) && !rst;
  assign if_rdata     = mem_q;
  assign dm_rdata     = mem_q;
  assign if_gnt       = if_gnt_s;
  assign dm_gnt       = dm_gnt_s;
  assign stall_if     = if_req & ~if_gnt_s;
  assign stall_dm     = dm_req & ~dm_gnt_s;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with a behavioural RAM and a
// read-return scoreboard fed from a bench-side reference memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic        stall_if;
  logic        stall_dm;
  logic [15:0] conflict_cnt;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .stall_if(stall_if), .stall_dm(stall_dm),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'h20080007 : {16'hA500, 16'(i)};
  endfunction

  // Behavioural single-port RAM, read-before-write, one-cycle read latency
  logic [31:0] ram [1024];
  logic        ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_q <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_gnt;
    logic        e_dm_gnt;
  } vec_t;

  typedef struct packed {
    logic        is_if;
    logic [31:0] data;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb_q[$];
  logic [31:0] ref_mem [1024];
  logic [15:0] exp_conflict;
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(input logic r, input logic ir, input logic [9:0] ia,
                              input logic dr, input logic dw, input logic [9:0] da,
                              input logic [31:0] wd, input logic eig, input logic edg);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
    v.dm_addr = da; v.dm_wdata = wd; v.e_if_gnt = eig; v.e_dm_gnt = edg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic        e_if_rv;
    logic        e_dm_rv;
    logic [9:0]  e_addr;
    @(negedge clk);
    rst = v.rst; if_req = v.if_req; if_addr = v.if_addr; dm_req = v.dm_req;
    dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    #4;
    chk("if_gnt", 32'(if_gnt), 32'(v.e_if_gnt));
    chk("dm_gnt", 32'(dm_gnt), 32'(v.e_dm_gnt));
    chk("stall_if", 32'(stall_if), 32'(v.if_req & ~v.e_if_gnt));
    chk("stall_dm", 32'(stall_dm), 32'(v.dm_req & ~v.e_dm_gnt));
    chk("mem_wren", 32'(mem_wren), 32'(v.e_dm_gnt & v.dm_we));
    e_addr = v.e_if_gnt ? v.if_addr : (v.e_dm_gnt ? v.dm_addr : 10'd0);
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (!v.e_if_gnt) chk("mem_wdata", mem_wdata, v.e_dm_gnt ? v.dm_wdata : 32'd0);
    chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_conflict));
    e_if_rv = !v.rst && (sb_q.size() > 0) && sb_q[0].is_if;
    e_dm_rv = !v.rst && (sb_q.size() > 0) && !sb_q[0].is_if;
    chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
    if (e_if_rv) chk("if_rdata", if_rdata, sb_q[0].data);
    if (e_dm_rv) chk("dm_rdata", dm_rdata, sb_q[0].data);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    if (v.rst) begin
      exp_conflict = 16'd0;
    end else begin
      if (v.if_req && v.dm_req && exp_conflict != 16'hFFFF) exp_conflict = exp_conflict + 16'd1;
      if (v.e_if_gnt) sb_q.push_back('{1'b1, ref_mem[v.if_addr]});
      else if (v.e_dm_gnt && !v.dm_we) sb_q.push_back('{1'b0, ref_mem[v.dm_addr]});
      else if (v.e_dm_gnt && v.dm_we) ref_mem[v.dm_addr] = v.dm_wdata;
    end
  endtask

  initial begin
    rst = 1'b1; ram_load = 1'b1; if_req = 1'b0; if_addr = 10'd0; dm_req = 1'b0;
    dm_we = 1'b0; dm_addr = 10'd0; dm_wdata = 32'd0; exp_conflict = 16'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    @(posedge clk);
    #1 ram_load = 1'b0;

    // reset holds everything off even with both requests high
    vecs.push_back(mk(1'b1, 1'b1, 10'd5, 1'b1, 1'b1, 10'd9, 32'h1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 10'd5, 1'b1, 1'b1, 10'd9, 32'h1, 1'b0, 1'b0));
    // IF alone, then load vs fetch conflict
    vecs.push_back(mk(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 10'd6, 1'b1, 1'b0, 10'd12, 32'h0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    // six back-to-back loads against a waiting fetch: DM DM DM IF DM DM
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1'b0, 1'b1, 10'd7, 1'b1, 1'b0, 10'(20 + k), 32'h0,
                        (k == 3) ? 1'b1 : 1'b0, (k == 3) ? 1'b0 : 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    // store then fetch of the same word
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd3, 32'hDEADBEEF, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    // dm_we without dm_req is ignored
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd4, 32'h55, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    // read then write back-to-back: read returns the old word
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd12, 32'h0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd12, 32'h11111111, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 10'd12, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 10'd8, 1'b1, 1'b1, 10'd30, 32'h12345678, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    // reset with an IF read in flight, then a clean first grant
    vecs.push_back(mk(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    // reset clears a partially built starvation count
    vecs.push_back(mk(1'b0, 1'b1, 10'd9, 1'b1, 1'b0, 10'd40, 32'h0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 10'd9, 1'b1, 1'b0, 10'd41, 32'h0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1'b0, 1'b1, 10'd9, 1'b1, 1'b0, 10'(42 + k), 32'h0,
                        (k == 3) ? 1'b1 : 1'b0, (k == 3) ? 1'b0 : 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0));

    foreach (vecs[i]) apply(vecs[i]);

    // saturation of the conflict counter
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #4 chk("conflict_after_rst", 32'(conflict_cnt), 32'd0);
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
      dm_addr = 10'(i); if_addr = 10'(i);
    end
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0;
    #4 chk("conflict_sat", 32'(conflict_cnt), 32'h0000FFFF);
    @(negedge clk);
    #4 chk("conflict_hold", 32'(conflict_cnt), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port synchronous RAM between the pipeline's instruction-fetch stage and its memory stage. This lets one unified memory replace the separate instruction and data memories. Each cycle it grants at most one requester, routes read data back one cycle later, and raises a stall toward the losing stage. A starvation counter guarantees that instruction fetch makes forward progress under back-to-back loads and stores.

## Interface
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data word width
- STARVE_MAX, 3, consecutive cycles IF may be denied before it wins priority (1..15)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  instruction read request (level, held until granted)
- if_addr  in  ADDR_W  instruction word address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  if_rdata valid (one cycle)
- if_rdata  out  DATA_W  instruction word
- dm_req  in  1  data request (level, held until granted)
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  DM request accepted this cycle
- dm_rvalid  out  1  dm_rdata valid (one cycle, loads only)
- dm_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  DATA_W  RAM read data, valid the cycle after its address is presented
- stall_if  out  1  if_req & ~if_gnt
- stall_dm  out  1  dm_req & ~dm_gnt
- conflict_cnt  out  16  saturating count of cycles in which both requests were high

## Operation
- Grants are combinational from the requests and registered state:
  - Only one request high: that request is granted.
  - Both high: DM wins by default. IF wins when starve_cnt == STARVE_MAX.
- starve_cnt (4 bit):
  - Increments when if_req is high and IF is not granted.
  - Clears to 0 when IF is granted or if_req is low.
  - Never exceeds STARVE_MAX.
- RAM drive:
  - IF granted: mem_addr = if_addr, mem_wren = 0.
  - DM granted: mem_addr = dm_addr, mem_wdata = dm_wdata, mem_wren = dm_we.
  - No grant: mem_addr = 0, mem_wdata = 0, mem_wren = 0.
- Read return uses a registered tag, pend ∈ {NONE, IF, DM}:
  - Set to IF on an IF grant.
  - Set to DM on a DM grant with dm_we = 0.
  - Otherwise set to NONE.
  - Next cycle: if_rvalid = (pend == IF), dm_rvalid = (pend == DM), and both rdata outputs = mem_q (data qualified only by its rvalid).
- Stores produce no rvalid. The store completes at the granting edge.
- conflict_cnt increments on every cycle where if_req & dm_req, and saturates at 16'hFFFF.

## Timing
- Grant to rvalid latency is 1 cycle for reads. A new grant may be issued every cycle (full throughput, no bubbles).
- The requester samples its gnt in the same cycle. When gnt is seen, it may change addr and req at the next edge.
- A read granted in cycle N and a write granted in cycle N+1 are both legal; rvalid for the read appears in N+1.
- Reset (any cycle, including with a read in flight):
  - pend = NONE, starve_cnt = 0, conflict_cnt = 0.
  - No rvalid is produced in the cycle after reset for a pre-reset grant.
  - While rst is high: gnts = 0, rvalids = 0, mem_wren = 0, mem_addr = 0, mem_wdata = 0, and stalls follow the stall equations with gnts forced to 0.
- Request with dm_we = 1 and dm_req = 0: ignored.

## Structure
- Shared package: the pend encoding (PEND_NONE = 2'd0, PEND_IF = 2'd1, PEND_DM = 2'd2) and the default ADDR_W/DATA_W constants. These are reused by the pipeline top.
- Single module. No sub-module is needed.
- The RAM stays outside the block and is instantiated by the pipeline top.

## Test plan
- After reset, IF only, if_addr = 5, mem holds 0x20080007 at 5 → if_gnt = 1 at once; next cycle if_rvalid = 1 and if_rdata = 0x20080007; stall_if = 0 throughout.
- Both request, dm_we = 0, dm_addr = 12 → dm_gnt = 1 and stall_if = 1; next cycle dm_rvalid = 1 with mem[12]; conflict_cnt = 1.
- dm_req held high with a stream of loads for 6 cycles while if_req stays high → IF is denied for 3 cycles, then granted in the 4th cycle (stall_dm = 1 that cycle), then DM wins again; conflict_cnt = 6.
- Store dm_we = 1, dm_addr = 3, dm_wdata = 0xDEADBEEF, then IF read of address 3 → mem_wren = 1 for exactly one cycle and no dm_rvalid; the IF read returns 0xDEADBEEF.
- IF granted, then rst asserted on the next edge → if_rvalid stays 0, all counters are 0, and after release the first grant behaves as in scenario 1.
- Force 65540 conflict cycles → conflict_cnt holds at 0xFFFF.
